// File: rtl/eaglesong_pkg.sv
// Shared constants, FSM encoding and rotate helper for the Eaglesong permutation blocks.
package eaglesong_pkg;

    localparam int EAGLESONG_NUM_WORDS      = 16;
    localparam int EAGLESONG_WORD_WIDTH     = 32;
    localparam int EAGLESONG_COEFS_PER_WORD = 3;
    localparam int EAGLESONG_NUM_COEFS      = 48;
    localparam int EAGLESONG_STATE_W        = EAGLESONG_NUM_WORDS * EAGLESONG_WORD_WIDTH;
    localparam int COEF_INDEX_W             = 6;
    localparam int COEF_W                   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Rotating a doubled word keeps the wrapped bits in the upper half, so amount 0 is identity.
    function automatic logic [EAGLESONG_WORD_WIDTH-1:0] rotl32(
        input logic [EAGLESONG_WORD_WIDTH-1:0] x,
        input logic [COEF_W-1:0]               amt
    );
        logic [2*EAGLESONG_WORD_WIDTH-1:0] doubled;
        doubled = {x, x} << amt;
        return doubled[2*EAGLESONG_WORD_WIDTH-1:EAGLESONG_WORD_WIDTH];
    endfunction

endpackage

// File: rtl/eaglesong_circulant_sequencer_if.sv
// Request/result handshake plus the external coefficient ROM port pair of the circulant sequencer.
interface eaglesong_circulant_sequencer_if;
    import eaglesong_pkg::*;

    logic                         start;
    logic                         ready;
    logic [EAGLESONG_STATE_W-1:0] state_in;
    logic [EAGLESONG_STATE_W-1:0] state_out;
    logic                         done;
    logic [COEF_INDEX_W-1:0]      coef_index;
    logic [COEF_W-1:0]            coef_value;

    // The master side owns the request and the ROM data; the sequencer owns addressing and results.
    modport master (
        output start, state_in, coef_value,
        input  ready, state_out, done, coef_index
    );

    modport slave (
        input  start, state_in, coef_value,
        output ready, state_out, done, coef_index
    );

endinterface

// File: rtl/eaglesong_circulant_lane.sv
// One circulant term: rotate the current word by the ROM coefficient and fold it into the accumulator.
module eaglesong_circulant_lane
    import eaglesong_pkg::*;
(
    input  logic [EAGLESONG_WORD_WIDTH-1:0] word,
    input  logic [COEF_W-1:0]               coef,
    input  logic [EAGLESONG_WORD_WIDTH-1:0] acc,
    input  logic [1:0]                      j,
    output logic [EAGLESONG_WORD_WIDTH-1:0] acc_next
);

    logic [EAGLESONG_WORD_WIDTH-1:0] rotated;

    // The first term of a word restarts the accumulator; later terms XOR into it.
    always_comb begin
        rotated  = rotl32(word, coef);
        acc_next = (j == 2'd0) ? rotated : (acc ^ rotated);
    end

endmodule

// File: rtl/eaglesong_circulant_sequencer.sv
// Walks the 16 state words through the 48-entry coefficient ROM, one rotation term per cycle,
// building new_s[i] = rotl(s[i],c[3i]) ^ rotl(s[i],c[3i+1]) ^ rotl(s[i],c[3i+2]).
module eaglesong_circulant_sequencer
    import eaglesong_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    eaglesong_circulant_sequencer_if.slave    bus
);

    localparam logic [COEF_INDEX_W-1:0] LAST_INDEX = COEF_INDEX_W'(EAGLESONG_NUM_COEFS - 1);

    seq_state_t                                                state;
    logic [EAGLESONG_NUM_WORDS-1:0][EAGLESONG_WORD_WIDTH-1:0] s_reg;
    logic [EAGLESONG_NUM_WORDS-1:0][EAGLESONG_WORD_WIDTH-1:0] state_out_q;
    logic [EAGLESONG_WORD_WIDTH-1:0]                           acc;
    logic [EAGLESONG_WORD_WIDTH-1:0]                           lane_out;
    logic [3:0]                                                word_cnt;
    logic [1:0]                                                j_cnt;
    logic [COEF_INDEX_W-1:0]                                   idx;
    logic                                                      done_q;
    logic                                                      ready_q;

    eaglesong_circulant_lane u_lane (
        .word     (s_reg[word_cnt]),
        .coef     (bus.coef_value),
        .acc      (acc),
        .j        (j_cnt),
        .acc_next (lane_out)
    );

    // idx doubles as the ROM address; word_cnt/j_cnt track idx/3 and idx%3 without a divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            s_reg       <= '0;
            state_out_q <= '0;
            acc         <= '0;
            word_cnt    <= '0;
            j_cnt       <= '0;
            idx         <= '0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        s_reg    <= bus.state_in;
                        word_cnt <= '0;
                        j_cnt    <= '0;
                        idx      <= '0;
                        ready_q  <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= lane_out;
                    if (j_cnt == 2'd2) begin
                        state_out_q[word_cnt] <= lane_out;
                        j_cnt                 <= 2'd0;
                        word_cnt              <= word_cnt + 4'd1;
                    end else begin
                        j_cnt <= j_cnt + 2'd1;
                    end
                    // Parking the address at 0 keeps the ROM inside its 48 valid entries.
                    if (idx == LAST_INDEX) begin
                        idx    <= '0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    idx     <= '0;
                end
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.done       = done_q;
    assign bus.coef_index = idx;
    assign bus.state_out  = state_out_q;

endmodule

// File: tb/tb_eaglesong_circulant_sequencer.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor checks handshake timing and results.
module tb_eaglesong_circulant_sequencer;
    import eaglesong_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eaglesong_circulant_sequencer_if bus();

    eaglesong_circulant_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [4:0] romTable [0:47] = '{
        5'd0, 5'd2,  5'd4,  5'd0, 5'd13, 5'd22, 5'd0, 5'd4,  5'd19, 5'd0, 5'd3,  5'd14,
        5'd0, 5'd27, 5'd31, 5'd0, 5'd3,  5'd8,  5'd0, 5'd17, 5'd26, 5'd0, 5'd3,  5'd12,
        5'd0, 5'd18, 5'd22, 5'd0, 5'd12, 5'd18, 5'd0, 5'd4,  5'd7,  5'd0, 5'd4,  5'd31,
        5'd0, 5'd12, 5'd27, 5'd0, 5'd7,  5'd17, 5'd0, 5'd7,  5'd8,  5'd0, 5'd1,  5'd13
    };

    assign bus.coef_value = (bus.coef_index < 6'd48) ? romTable[bus.coef_index] : 5'd0;

    int           checks = 0;
    int           errors = 0;
    logic [511:0] expQ [$];
    int           phase = 0;
    bit           modelValid = 1'b0;
    int           resetEpoch = 0;
    int           seenEpoch = 0;
    logic [511:0] lastResult = '0;
    int           pushed = 0;
    int           dropped = 0;
    int           doneCount = 0;

    task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: each new word is the XOR of three rotations of the old word by its table coefficients.
    function automatic logic [511:0] refCirculant(input logic [511:0] s);
        logic [511:0] result;
        logic [31:0]  x;
        logic [63:0]  wide;
        result = '0;
        for (int w = 0; w < 16; w++) begin
            x = s[32*w +: 32];
            for (int k = 0; k < 3; k++) begin
                wide = {32'd0, x} << romTable[3*w + k];
                result[32*w +: 32] = result[32*w +: 32] ^ (wide[31:0] | wide[63:32]);
            end
        end
        return result;
    endfunction

    function automatic logic [511:0] randomState();
        logic [511:0] s;
        for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom();
        return s;
    endfunction

    // Phase 0 idle, 1..48 run with address phase-1, 49 is the done cycle.
    always @(posedge clk) begin
        if (rst) begin
            dropped    <= dropped + expQ.size();
            expQ.delete();
            phase      <= 0;
            resetEpoch <= resetEpoch + 1;
            modelValid <= 1'b1;
        end else if (phase == 0) begin
            if (bus.start) phase <= 1;
        end else if (phase == 49) begin
            phase <= 0;
        end else begin
            phase <= phase + 1;
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            if (seenEpoch != resetEpoch) begin
                seenEpoch  = resetEpoch;
                lastResult = '0;
            end
            checkOutput("ready", 512'(bus.ready), 512'(phase == 0));
            checkOutput("done", 512'(bus.done), 512'(phase == 49));
            checkOutput("coef_index", 512'(bus.coef_index),
                        512'((phase >= 1 && phase <= 48) ? phase - 1 : 0));
            if (phase == 49) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 512'(1), 512'(0));
                end else begin
                    lastResult = expQ.pop_front();
                    checkOutput("state_out_at_done", bus.state_out, lastResult);
                end
            end else if (phase == 0) begin
                checkOutput("state_out_hold", bus.state_out, lastResult);
            end
        end
    end

    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        while (!(phase == 0 && expQ.size() == 0) && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("idle_timeout", 512'(phase == 0 && expQ.size() == 0), 512'(1));
    endtask

    task automatic applyStimulus(input logic [511:0] s, input logic [511:0] expected);
        int n;
        n = 0;
        while (phase != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("ready_timeout", 512'(phase == 0), 512'(1));
        bus.start    = 1'b1;
        bus.state_in = s;
        expQ.push_back(expected);
        pushed++;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.state_in = randomState();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    logic [511:0] t2In;
    logic [511:0] t2Exp;
    int           n;

    initial begin
        bus.start    = 1'b0;
        bus.state_in = '0;
        t2In  = '0;
        t2In[31:0]    = 32'h00000001;
        t2In[63:32]   = 32'h00000001;
        t2In[159:128] = 32'h80000000;
        t2Exp = '0;
        t2Exp[31:0]    = 32'h00000015;
        t2Exp[63:32]   = 32'h00402001;
        t2Exp[159:128] = 32'hC4000000;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] all-zero state");
        applyStimulus('0, '0);
        waitIdle(200);

        $display("[TB] directed single-bit words");
        applyStimulus(t2In, t2Exp);
        waitIdle(200);

        $display("[TB] all-ones state");
        applyStimulus({512{1'b1}}, {512{1'b1}});
        waitIdle(200);

        $display("[TB] stray starts during RUN and DONE");
        applyStimulus(t2In, t2Exp);
        repeat (10) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        while (phase != 49 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("reach_done_phase", 512'(phase == 49), 512'(1));
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        t2In = randomState();
        applyStimulus(t2In, refCirculant(t2In));
        waitIdle(200);

        $display("[TB] reset during RUN");
        t2In = randomState();
        applyStimulus(t2In, refCirculant(t2In));
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        t2In = randomState();
        applyStimulus(t2In, refCirculant(t2In));
        waitIdle(200);

        $display("[TB] random states");
        for (int i = 0; i < 20; i++) begin
            t2In = randomState();
            applyStimulus(t2In, refCirculant(t2In));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        waitIdle(200);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_count", 512'(doneCount), 512'(pushed - dropped));
        checkOutput("queue_empty", 512'(expQ.size()), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
